// File: rtl/othfsm_tx_sched.sv
// rtl/othfsm_tx_sched.sv - round-robin two-requester scheduler serializing 18-bit flag/ID/payload/parity frames
module othfsm_tx_sched #(
  parameter int DIV = 4,
  parameter int GAP = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       ClkEn,
  input  logic [1:0] Req,
  input  logic [7:0] Data0,
  input  logic [7:0] Data1,
  output logic [1:0] Ack,
  output logic       SerOut,
  output logic       SerOutValid,
  output logic       BitEn,
  output logic       Busy,
  output logic [3:0] CntOut
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BMAX = (GAP > 8) ? GAP : 8;
  localparam int BW = $clog2(BMAX);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] GAP_LAST = BW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_FLAG, S_ID, S_DATA, S_PAR, S_GAP
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [DW-1:0] div;
  logic [BW-1:0] bit_idx;
  logic [BW-1:0] bit_last;
  logic [17:0]   sr;
  logic          ptr;
  logic [1:0]    ack_q;
  logic [3:0]    cnt;
  logic          div_end;
  logic          bit_end;
  logic          grant;
  logic          gnt_id;
  logic [7:0]    pay;

  always_comb begin
    bit_last = '0;
    case (state)
      S_FLAG:  bit_last = BW'(7);
      S_DATA:  bit_last = BW'(7);
      S_GAP:   bit_last = GAP_LAST;
      default: bit_last = '0;
    endcase
  end

  assign div_end = (div == DIV_LAST);
  assign bit_end = div_end && (bit_idx == bit_last);
  assign grant   = (state == S_IDLE) && ClkEn && (Req != 2'b00);
  // ptr names the requester that wins a tie; cleared means requester 0
  assign gnt_id  = (Req == 2'b11) ? ptr : Req[1];
  assign pay     = gnt_id ? Data1 : Data0;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (ClkEn) begin
      case (state)
        S_IDLE:  if (Req != 2'b00) state_n = S_FLAG;
        S_FLAG:  if (bit_end) state_n = S_ID;
        S_ID:    if (bit_end) state_n = S_DATA;
        S_DATA:  if (bit_end) state_n = S_PAR;
        S_PAR:   if (bit_end) state_n = (GAP == 0) ? S_IDLE : S_GAP;
        S_GAP:   if (bit_end) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    SerOutValid = 1'b0;
    Busy        = 1'b0;
    BitEn       = 1'b0;
    SerOut      = sr[17];
    Ack         = ack_q;
    CntOut      = cnt;
    if (state != S_IDLE) Busy = 1'b1;
    if (state == S_FLAG || state == S_ID || state == S_DATA || state == S_PAR) begin
      SerOutValid = 1'b1;
      BitEn       = div_end;
    end
  end

  // The frame shifts out of sr with zero fill, so the line is already 0 once PAR ends
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      div     <= '0;
      bit_idx <= '0;
      sr      <= '0;
      ptr     <= 1'b0;
      ack_q   <= 2'b00;
      cnt     <= 4'd0;
    end else begin
      ack_q <= 2'b00;
      if (grant) begin
        ack_q   <= gnt_id ? 2'b10 : 2'b01;
        ptr     <= ~gnt_id;
        sr      <= {8'h7E, gnt_id, pay, ^{gnt_id, pay}};
        div     <= '0;
        bit_idx <= '0;
      end else if (ClkEn && state != S_IDLE) begin
        if (div_end) begin
          div     <= '0;
          bit_idx <= bit_end ? '0 : bit_idx + 1'b1;
          if (state != S_GAP) sr <= {sr[16:0], 1'b0};
          if (state == S_PAR) cnt <= cnt + 4'd1;
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end
endmodule
